// File: rtl/p_hit_point_pkg.sv
// -----------------------------------------------------------------------------
// p_hit_pkg
// Shared definitions for the hit-point stage (P = origin + t*dir).
//   VEC_LANES : number of vector components (x, y, z).
//   FX_W      : operand width accepted by the fixed-point helpers.
//   FX_PW     : full product width produced by the helpers.
//   fx_mul    : full-precision signed product, arithmetic shift right by q (floor).
//   fx_sat    : clamp a wide signed value into a signed range of 'width' bits.
// Callers sign-extend their operands to FX_W and truncate the results.
// -----------------------------------------------------------------------------
package p_hit_pkg;

    localparam int VEC_LANES = 3;
    localparam int FX_W      = 64;
    localparam int FX_PW     = 2 * FX_W;

    // Product is formed at full width so the shift sees every bit; >>> floors.
    function automatic logic signed [FX_PW-1:0] fx_mul(
        input logic signed [FX_W-1:0] a,
        input logic signed [FX_W-1:0] b,
        input int unsigned            q
    );
        logic signed [FX_PW-1:0] prod;
        prod = FX_PW'(a) * FX_PW'(b);
        return prod >>> q;
    endfunction

    function automatic logic signed [FX_PW-1:0] fx_sat(
        input logic signed [FX_PW-1:0] value,
        input int unsigned             width
    );
        logic signed [FX_PW-1:0] one;
        logic signed [FX_PW-1:0] hi;
        logic signed [FX_PW-1:0] lo;
        one = FX_PW'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/p_hit_point_if.sv
// -----------------------------------------------------------------------------
// p_hit_point_if
// Bundles the upstream FWFT-FIFO read side and the output FIFO read side of
// the hit-point stage.
//   in_empty / in_rd_en        : upstream FIFO status and pop.
//   t, origin[], dir[], tag    : one bundled ray word (valid when !in_empty).
//   out[], out_tag, out_hit    : head entry of the output FIFO.
//   out_empty / out_rd_en      : output FIFO status and pop.
// Modports: slave = the hit-point stage, master = its environment.
// -----------------------------------------------------------------------------
interface p_hit_point_if
    import p_hit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
);
    logic                         in_empty;
    logic                         in_rd_en;
    logic signed [DATA_WIDTH-1:0] t;
    logic signed [DATA_WIDTH-1:0] origin [VEC_LANES];
    logic signed [DATA_WIDTH-1:0] dir    [VEC_LANES];
    logic        [TAG_WIDTH-1:0]  tag;
    logic signed [DATA_WIDTH-1:0] out    [VEC_LANES];
    logic        [TAG_WIDTH-1:0]  out_tag;
    logic                         out_hit;
    logic                         out_empty;
    logic                         out_rd_en;

    modport slave (
        input  in_empty, t, origin, dir, tag, out_rd_en,
        output in_rd_en, out, out_tag, out_hit, out_empty
    );

    modport master (
        output in_empty, t, origin, dir, tag, out_rd_en,
        input  in_rd_en, out, out_tag, out_hit, out_empty
    );
endinterface

// File: rtl/p_hit_point_lane.sv
// -----------------------------------------------------------------------------
// p_hit_point_lane
// One vector component of the hit-point datapath.
//   S2 (registered): scaled = (t * dir) >>> Q_BITS, truncated to DATA_WIDTH.
//   S3 (combinational, consumed by the output FIFO write): sum = origin + scaled.
// Ports:
//   clock, reset : clock and asynchronous active-high reset.
//   t, dir, origin : S1-registered operands.
//   sum            : S3 result, valid while the matching S2 valid is set.
// Build option P_HIT_POINT_SAT_EN: clamp S2 and S3 results instead of wrapping.
// -----------------------------------------------------------------------------
module p_hit_point_lane
    import p_hit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int Q_BITS     = 16
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] t,
    input  logic signed [DATA_WIDTH-1:0] dir,
    input  logic signed [DATA_WIDTH-1:0] origin,
    output logic signed [DATA_WIDTH-1:0] sum
);
    logic signed [DATA_WIDTH-1:0] scaled_next;
    logic signed [DATA_WIDTH-1:0] scaled_reg;
    logic signed [DATA_WIDTH-1:0] origin_reg;

`ifdef P_HIT_POINT_SAT_EN
    assign scaled_next = DATA_WIDTH'(fx_sat(fx_mul(FX_W'(t), FX_W'(dir), Q_BITS), DATA_WIDTH));
    // Sum at DATA_WIDTH+1 bits cannot overflow; clamp that back into range.
    assign sum = DATA_WIDTH'(fx_sat(FX_PW'((DATA_WIDTH+1)'(origin_reg) + (DATA_WIDTH+1)'(scaled_reg)),
                                    DATA_WIDTH));
`else
    assign scaled_next = DATA_WIDTH'(fx_mul(FX_W'(t), FX_W'(dir), Q_BITS));
    assign sum = DATA_WIDTH'((DATA_WIDTH+1)'(origin_reg) + (DATA_WIDTH+1)'(scaled_reg));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scaled_reg <= '0;
            origin_reg <= '0;
        end else begin
            scaled_reg <= scaled_next;
            origin_reg <= origin;
        end
    end
endmodule

// File: rtl/p_hit_point.sv
// -----------------------------------------------------------------------------
// p_hit_point
// Hit-point stage: P = origin + t*dir per ray in signed Q(DATA_WIDTH-Q_BITS).Q_BITS
// with a hit flag (t > T_MIN) and pass-through tag, buffered in an output FIFO.
// Ports:
//   clock, reset : clock and asynchronous active-high reset.
//   bus (slave)  : upstream FWFT read side (in_empty, in_rd_en, t, origin, dir,
//                  tag) and output FIFO read side (out, out_tag, out_hit,
//                  out_empty, out_rd_en).
// Pipeline: S1 input registers + hit compare, S2 scaled products (lanes),
// S3 sums written into the FIFO. A credit counter (in-flight + buffered)
// throttles in_rd_en so the FIFO can never be written while full.
// Build option P_HIT_POINT_SAT_EN (in p_hit_point_lane): saturating arithmetic.
// -----------------------------------------------------------------------------
module p_hit_point
    import p_hit_pkg::*;
#(
    parameter int                           DATA_WIDTH = 32,
    parameter int                           Q_BITS     = 16,
    parameter int                           OUT_DEPTH  = 8,
    parameter int                           TAG_WIDTH  = 8,
    parameter logic signed [DATA_WIDTH-1:0] T_MIN      = 'sd1
)(
    input logic          clock,
    input logic          reset,
    p_hit_point_if.slave bus
);
    localparam int               PTR_W   = $clog2(OUT_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    logic                         rd_en;
    logic                         push;
    logic                         pop;
    logic                         fifo_empty;
    logic [CNT_W-1:0]             credit_reg;
    logic [CNT_W-1:0]             credit_next;
    logic [CNT_W-1:0]             count_reg;
    logic [CNT_W-1:0]             count_next;
    logic [PTR_W-1:0]             wr_ptr_reg;
    logic [PTR_W-1:0]             rd_ptr_reg;

    logic                         s1_valid_reg;
    logic                         s1_hit_reg;
    logic [TAG_WIDTH-1:0]         s1_tag_reg;
    logic signed [DATA_WIDTH-1:0] s1_t_reg;
    logic signed [DATA_WIDTH-1:0] s1_origin_reg [VEC_LANES];
    logic signed [DATA_WIDTH-1:0] s1_dir_reg    [VEC_LANES];
    logic                         s2_valid_reg;
    logic                         s2_hit_reg;
    logic [TAG_WIDTH-1:0]         s2_tag_reg;

    logic [TAG_WIDTH-1:0]         tag_mem [OUT_DEPTH];
    logic                         hit_mem [OUT_DEPTH];

    assign fifo_empty  = (count_reg == '0);
    // Credits count every ray between the upstream pop and the output pop.
    assign rd_en       = !reset && !bus.in_empty && (credit_reg < DEPTH_C);
    assign push        = s2_valid_reg;
    assign pop         = bus.out_rd_en && !fifo_empty;
    assign credit_next = credit_reg + CNT_W'(rd_en) - CNT_W'(pop);
    assign count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);

    assign bus.in_rd_en  = rd_en;
    assign bus.out_empty = fifo_empty;
    assign bus.out_tag   = fifo_empty ? '0 : tag_mem[rd_ptr_reg];
    assign bus.out_hit   = fifo_empty ? 1'b0 : hit_mem[rd_ptr_reg];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= 1'b0;
            s1_tag_reg   <= '0;
            s1_t_reg     <= '0;
            for (int i = 0; i < VEC_LANES; i++) begin
                s1_origin_reg[i] <= '0;
                s1_dir_reg[i]    <= '0;
            end
            s2_valid_reg <= 1'b0;
            s2_hit_reg   <= 1'b0;
            s2_tag_reg   <= '0;
            credit_reg   <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            s1_valid_reg <= rd_en;
            s1_hit_reg   <= (bus.t > T_MIN);
            s1_tag_reg   <= bus.tag;
            s1_t_reg     <= bus.t;
            for (int i = 0; i < VEC_LANES; i++) begin
                s1_origin_reg[i] <= bus.origin[i];
                s1_dir_reg[i]    <= bus.dir[i];
            end
            s2_valid_reg <= s1_valid_reg;
            s2_hit_reg   <= s1_hit_reg;
            s2_tag_reg   <= s1_tag_reg;
            credit_reg   <= credit_next;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Buffer storage carries no reset; the empty flag masks stale entries.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= s2_tag_reg;
            hit_mem[wr_ptr_reg] <= s2_hit_reg;
        end
    end

    for (genvar gi = 0; gi < VEC_LANES; gi++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] lane_sum;
        logic signed [DATA_WIDTH-1:0] data_mem [OUT_DEPTH];

        p_hit_point_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .Q_BITS     (Q_BITS)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .t      (s1_t_reg),
            .dir    (s1_dir_reg[gi]),
            .origin (s1_origin_reg[gi]),
            .sum    (lane_sum)
        );

        always_ff @(posedge clock) begin
            if (push) begin
                data_mem[wr_ptr_reg] <= lane_sum;
            end
        end

        assign bus.out[gi] = fifo_empty ? '0 : data_mem[rd_ptr_reg];
    end

    a_no_fifo_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count_reg == DEPTH_C)));
endmodule

// File: tb/tb_p_hit_point.sv
// -----------------------------------------------------------------------------
// tb_p_hit_point
// Directed bench for p_hit_point (OUT_DEPTH = 4). Upstream is an FWFT queue
// (src_q); every ray's expected result travels in exp_q and is compared when
// the ray leaves the output FIFO. Overflow expectations follow
// P_HIT_POINT_SAT_EN.
// -----------------------------------------------------------------------------
module tb_p_hit_point;
    import p_hit_pkg::*;

    localparam int DW    = 32;
    localparam int TW    = 8;
    localparam int DEPTH = 4;

`ifdef P_HIT_POINT_SAT_EN
    localparam logic [31:0] OVF_MUL_X = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_ADD_X = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_MUL_X = 32'hFFFE_0000;
    localparam logic [31:0] OVF_ADD_X = 32'h8000_FFFF;
`endif

    typedef struct packed {
        logic [31:0]       t;
        logic [2:0][31:0]  o;
        logic [2:0][31:0]  d;
        logic [7:0]        tag;
        logic [2:0][31:0]  e;
        logic              eh;
    } ray_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    p_hit_point_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    p_hit_point #(
        .DATA_WIDTH (DW),
        .Q_BITS     (16),
        .OUT_DEPTH  (DEPTH),
        .TAG_WIDTH  (TW),
        .T_MIN      (32'sd1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ray_t src_q[$];
    ray_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   rd_pulses = 0;
    int   s_cyc     = 0;
    logic s_rd, s_empty, s_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_ray(input logic [31:0] t, ox, oy, oz, dx, dy, dz,
                           input logic [7:0] tag,
                           input logic [31:0] ex, ey, ez,
                           input logic eh);
        ray_t r;
        r.t = t;  r.tag = tag;  r.eh = eh;
        r.o[0] = ox; r.o[1] = oy; r.o[2] = oz;
        r.d[0] = dx; r.d[1] = dy; r.d[2] = dz;
        r.e[0] = ex; r.e[1] = ey; r.e[2] = ez;
        src_q.push_back(r);
        exp_q.push_back(r);
    endtask

    task automatic drive();
        if (src_q.size() != 0) begin
            bus.in_empty = 1'b0;
            bus.t        = src_q[0].t;
            bus.tag      = src_q[0].tag;
            for (int i = 0; i < VEC_LANES; i++) begin
                bus.origin[i] = src_q[0].o[i];
                bus.dir[i]    = src_q[0].d[i];
            end
        end else begin
            bus.in_empty = 1'b1;
        end
    endtask

    task automatic compare_head();
        ray_t e;
        if (exp_q.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            $display("out tag=%0d x=%h y=%h z=%h hit=%0d",
                     bus.out_tag, bus.out[0], bus.out[1], bus.out[2], bus.out_hit);
            check("out_x",   $unsigned(bus.out[0]), e.e[0]);
            check("out_y",   $unsigned(bus.out[1]), e.e[1]);
            check("out_z",   $unsigned(bus.out[2]), e.e[2]);
            check("out_tag", bus.out_tag, e.tag);
            check("out_hit", bus.out_hit, e.eh);
        end
    endtask

    // One clock: sample mid-cycle, then advance and update upstream.
    task automatic step();
        @(negedge clock);
        s_rd    = bus.in_rd_en;
        s_empty = bus.out_empty;
        s_cyc   = cyc;
        s_pop   = bus.out_rd_en && !bus.out_empty;
        if (s_pop) compare_head();
        if (s_rd) rd_pulses++;
        @(posedge clock);
        #1;
        cyc++;
        if (s_rd) begin
            if (src_q.size() != 0) src_q.delete(0);
            else check("rd_while_empty", 64'd1, 64'd0);
        end
        drive();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 64'd0);
    endtask

    function automatic logic [31:0] model_lane(input logic [31:0] t, o, d);
        longint p;
        p = longint'($signed(t)) * longint'($signed(d));
        p = p >>> 16;
        return o + p[31:0];
    endfunction

    task automatic add_basic(input logic [7:0] tag);
        add_ray(32'h0002_0000, 32'h1_0000, 32'h2_0000, 32'h3_0000,
                32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000, tag,
                32'h2_0000, 32'h0, 32'h3_8000, 1'b1);
    endtask

    initial begin
        int rd_cyc, first_pop, last_pop, n_pop, start_cyc;
        bit done;
        bus.in_empty  = 1'b1;
        bus.out_rd_en = 1'b0;
        bus.t         = '0;
        bus.tag       = '0;
        for (int i = 0; i < VEC_LANES; i++) begin
            bus.origin[i] = '0;
            bus.dir[i]    = '0;
        end
        repeat (2) @(posedge clock);
        #1;

        // Reset state, with a ray waiting upstream.
        add_basic(8'd1);
        drive();
        #1;
        check("rst_in_rd_en",  bus.in_rd_en, 1'b0);
        check("rst_out_empty", bus.out_empty, 1'b1);
        check("rst_out_x",     $unsigned(bus.out[0]), 32'h0);
        check("rst_out_tag",   bus.out_tag, 8'h0);
        check("rst_out_hit",   bus.out_hit, 1'b0);
        src_q.delete();
        exp_q.delete();
        drive();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic ray and first-output latency.
        add_basic(8'd5);
        drive();
        rd_cyc = -1;
        done   = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            step();
            if (s_rd && rd_cyc < 0) rd_cyc = s_cyc;
            if (!s_empty) begin
                done = 1'b1;
                check("latency", s_cyc - rd_cyc, 64'd3);
            end
        end
        if (!done) check("latency_timeout", 64'd0, 64'd1);
        bus.out_rd_en = 1'b1;
        step();

        // Miss, T_MIN boundary, floor, overflow vectors.
        add_ray(32'hFFFF_0000, 32'h1_0000, 32'h2_0000, 32'h3_0000,
                32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000, 8'd6,
                32'h0_8000, 32'h3_0000, 32'h2_C000, 1'b0);
        add_ray(32'h0000_0001, 32'h1_0000, 32'h2_0000, 32'h3_0000,
                32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000, 8'd7,
                32'h1_0000, 32'h1_FFFF, 32'h3_0000, 1'b0);
        add_ray(32'h0000_0002, 32'h1_0000, 32'h2_0000, 32'h3_0000,
                32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000, 8'd8,
                32'h1_0001, 32'h1_FFFE, 32'h3_0000, 1'b1);
        add_ray(32'h0000_0003, 32'h1_0000, 32'h2_0000, 32'h3_0000,
                32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0001, 8'd9,
                32'h0_FFFF, 32'h2_0003, 32'h3_0000, 1'b1);
        add_ray(32'h7FFF_0000, 32'h0, 32'h0, 32'h0,
                32'h0002_0000, 32'h0, 32'h0, 8'd10,
                OVF_MUL_X, 32'h0, 32'h0, 1'b1);
        add_ray(32'h0001_0000, 32'h7FFF_FFFF, 32'h0, 32'h0,
                32'h0001_0000, 32'h0, 32'h0, 8'd11,
                OVF_ADD_X, 32'h0, 32'h0, 1'b1);
        drive();
        drain(60);

        // Backpressure: only DEPTH rays may be taken while nothing drains.
        bus.out_rd_en = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            add_ray(32'h0001_0000, 32'(i), 32'h0, 32'h0,
                    32'h0001_0000, 32'h0002_0000, 32'h0, 8'(8'd20 + 8'(i)),
                    32'h1_0000 + 32'(i), 32'h2_0000, 32'h0, 1'b1);
        end
        drive();
        repeat (20) step();
        check("bp_rd_pulses", rd_pulses, 64'd4);
        check("bp_src_left",  src_q.size(), 64'd6);
        bus.out_rd_en = 1'b1;
        drain(60);
        check("bp_rd_total", rd_pulses, 64'd10);

        // Popping an empty FIFO must not disturb anything.
        repeat (3) step();
        check("idle_empty", s_empty, 1'b1);

        // Streaming: one result per clock after the fill.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] tv, ox, oy, oz, dx, dy, dz;
            tv = 32'($urandom_range(0, 2097152)) - 32'd1048576;
            dx = 32'($urandom_range(0, 2097152)) - 32'd1048576;
            dy = 32'($urandom_range(0, 2097152)) - 32'd1048576;
            dz = 32'($urandom_range(0, 2097152)) - 32'd1048576;
            ox = 32'($urandom_range(0, 1073741824)) - 32'd536870912;
            oy = 32'($urandom_range(0, 1073741824)) - 32'd536870912;
            oz = 32'($urandom_range(0, 1073741824)) - 32'd536870912;
            add_ray(tv, ox, oy, oz, dx, dy, dz, 8'(i),
                    model_lane(tv, ox, dx), model_lane(tv, oy, dy), model_lane(tv, oz, dz),
                    ($signed(tv) > 32'sd1));
        end
        drive();
        start_cyc = cyc;
        first_pop = -1;
        last_pop  = -1;
        n_pop     = 0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            step();
            if (s_pop) begin
                if (first_pop < 0) first_pop = s_cyc;
                last_pop = s_cyc;
                n_pop++;
            end
        end
        check("stream_pops", n_pop, 64'd100);
        check("stream_fill", first_pop - start_cyc, 64'd3);
        check("stream_span", last_pop - first_pop, 64'd99);

        // Reset with 2 rays buffered and 2 in flight.
        bus.out_rd_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            add_basic(8'(8'h40 + 8'(i)));
        end
        drive();
        repeat (4) step();
        check("rs_buffered", s_empty, 1'b0);
        reset = 1'b1;
        #1;
        check("rs_in_rd_en",  bus.in_rd_en, 1'b0);
        check("rs_out_empty", bus.out_empty, 1'b1);
        check("rs_out_tag",   bus.out_tag, 8'h0);
        src_q.delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            add_basic(8'(8'h50 + 8'(i)));
        end
        bus.out_rd_en = 1'b1;
        drive();
        drain(40);
        repeat (4) step();
        check("post_rst_empty", s_empty, 1'b1);
        check("post_rst_rd",    rd_pulses, 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
